rc4_key_search: RTL and testbench
=================================

// Module: rc4_key_search
// PURPOSE
//  Parametrised RC4 brute-force engine, successor to the fixed init/shuffle/decrypt/search chain.
//  Per candidate key: builds S, runs the KSA shuffle, decrypts the ROM ciphertext into result RAM and checks the plaintext.
//  Steps the key from KEY_START by KEY_STEP until a valid plaintext is found or KEY_END is passed.
//  Several instances with offset KEY_START and equal KEY_STEP partition the key space.
// PARAMETERS
//  KEY_BYTES  3         key length in bytes; KEY_W = 8*KEY_BYTES
//  MSG_LEN    32        ciphertext/plaintext length in bytes (1..256)
//  KEY_START  0         first key tried (KEY_W bits)
//  KEY_END    'h3FFFFF  last key allowed (inclusive)
//  KEY_STEP   1         key increment, >=1
// PORTS
//  clk          in   1      single clock
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      one-cycle pulse; begins search when idle
//  s_addr       out  8      S memory address
//  s_data       out  8      S memory write data
//  s_wren       out  1      S memory write enable
//  s_q          in   8      S memory read data, 1-cycle latency
//  rom_addr     out  8      ciphertext ROM address (1-cycle latency)
//  rom_q        in   8      ciphertext ROM data
//  res_addr     out  8      result RAM address
//  res_data     out  8      result RAM write data
//  res_wren     out  1      result RAM write enable
//  busy         out  1      high from the cycle after an accepted start until done
//  done         out  1      level; high from search end until the next accepted start
//  found        out  1      valid with done; 1 = key_out decrypts to valid text
//  key_out      out  KEY_W  key under test while busy; final key when done
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, key register = KEY_START. Reset mid-search aborts immediately; memory contents are don't-care.
//  start is ignored while busy. start in IDLE/DONE clears done/found and loads KEY_START.
//  FSM: IDLE -> INIT -> SHUF -> DEC -> CHECK -> (NEXT_KEY -> INIT | DONE).
//  INIT: S[i]=i for i=0..255, one write per cycle (256 cycles).
//  SHUF: for i=0..255: j = j + S[i] + key[i mod KEY_BYTES] (mod 256), then swap S[i] and S[j].
//   Key byte 0 is the MSB: key[KEY_W-1 -: 8].
//  DEC: i=j=0; for k=0..MSG_LEN-1:
//   i=i+1; j=j+S[i]; swap; f = S[S[i]+S[j]]; res[k] = f ^ rom[k].
//   All additions are 8-bit and wrap mod 256.
//  Valid byte: 8'h61..8'h7A or 8'h20. found=1 only if all MSG_LEN bytes are valid.
//  Memory timing: an address driven in cycle N yields q in cycle N+1. A read of an address written the previous cycle returns the new data (FSM inserts the wait).
//  Swap when i==j: S unchanged.
//  NEXT_KEY: if key+KEY_STEP > KEY_END, or the addition overflows KEY_W, then DONE with found=0 and key_out = last key tried.
//   Otherwise key += KEY_STEP.
//  DONE: busy=0, done=1, found/key_out held. s_wren and res_wren are 0 outside INIT/SHUF/DEC.
//  Cycle budget per key: <= 256 + 6*256 + 8*MSG_LEN + 4.
// CONFIGURATION
//  RC4_EARLY_REJECT_EN defined: DEC aborts at the first invalid byte and goes to NEXT_KEY.
//   That byte is still written; result RAM beyond it keeps stale data.
//  RC4_EARLY_REJECT_EN undefined: every key decrypts all MSG_LEN bytes before CHECK.
//  found/key_out results are identical either way; only cycle counts and stale RAM differ.
// STRUCTURE
//  Package rc4_pkg: state enum rc4_state_t, S_SIZE=256, CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SP=8'h20, function is_valid_char().
//  Sub-module rc4_swap_seq: read S[a], read S[b], write both swapped.
//   Start/done handshake; owns the S-port mux; shared by SHUF and DEC.
// TESTING
//  Golden C/Python RC4 model encrypts a 32-byte lowercase message with key 24'h000249.
//  1 KEY_START=KEY_END='h249, start -> done=1 found=1 key_out='h249; result RAM == plaintext.
//  2 KEY_START='h240, KEY_END='h24F -> found=1 key_out='h249; busy high throughout, keys 'h240..'h249 visited in order.
//  3 KEY_START='h250, KEY_END='h25F -> done=1 found=0 key_out='h25F.
//  4 Two instances, KEY_STEP=2, starts 'h248 and 'h249 -> only the odd-start instance reports found.
//  5 reset_n low mid-SHUF -> all outputs 0 next cycle; a new start re-runs cleanly to the same result.
//  6 start pulses while busy are ignored; RC4_EARLY_REJECT_EN defined: scenario 2 takes fewer cycles, same key_out.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-search engine.
// Holds the top-level state enum, the sequencing phases and the plaintext character test.
package rc4_pkg;

  localparam int         S_SIZE  = 256;
  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_SHUF, ST_DEC, ST_CHECK, ST_NEXT_KEY, ST_DONE
  } rc4_state_t;

  typedef enum logic [2:0] {
    PH_RD, PH_J, PH_WAIT, PH_F, PH_WR
  } rc4_phase_t;

  typedef enum logic [2:0] {
    SW_IDLE, SW_RD_A, SW_RD_B, SW_WR_A, SW_WR_B
  } swap_state_t;

  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
  endfunction

endpackage

// File: rtl/rc4_swap_seq.sv
// Swaps S[a] and S[b] over the single S-memory port: read a, read b, write both back crossed.
// When idle the port carries the caller's own accesses; done is asserted during the final write.
module rc4_swap_seq
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] ext_addr,
  input  logic [7:0] ext_data,
  input  logic       ext_wren,
  input  logic [7:0] s_q,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wren,
  output logic       done,
  output logic [7:0] va,
  output logic [7:0] vb
);

  swap_state_t state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d, va_q, va_d, vb_q, vb_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    va_d    = va_q;
    vb_d    = vb_q;
    s_addr  = ext_addr;
    s_data  = ext_data;
    s_wren  = ext_wren;
    done    = 1'b0;
    unique case (state_q)
      SW_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = SW_RD_A;
        end
      end
      SW_RD_A: begin
        s_addr  = a_q;
        s_data  = '0;
        s_wren  = 1'b0;
        state_d = SW_RD_B;
      end
      SW_RD_B: begin
        s_addr  = b_q;
        s_data  = '0;
        s_wren  = 1'b0;
        va_d    = s_q;
        state_d = SW_WR_A;
      end
      // when a == b both writes land on the same cell and the last one restores it
      SW_WR_A: begin
        s_addr  = a_q;
        s_data  = s_q;
        s_wren  = 1'b1;
        vb_d    = s_q;
        state_d = SW_WR_B;
      end
      SW_WR_B: begin
        s_addr  = b_q;
        s_data  = va_q;
        s_wren  = 1'b1;
        done    = 1'b1;
        state_d = SW_IDLE;
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SW_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      va_q    <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  assign va = va_q;
  assign vb = vb_q;

endmodule

// File: rtl/rc4_key_search.sv
// RC4 brute-force key search: per key builds S, shuffles, decrypts the ROM and checks the text.
// Optional macro RC4_EARLY_REJECT_EN: abandon a key at its first invalid plaintext byte.
//
// state       | meaning
// ST_IDLE     | waiting for start after reset
// ST_INIT     | S[i] = i, one write per cycle
// ST_SHUF     | key schedule, one swap per i
// ST_DEC      | keystream generation and result write
// ST_CHECK    | decide found / try next key
// ST_NEXT_KEY | step key or finish when range exhausted
// ST_DONE     | result held until next start
module rc4_key_search
  import rc4_pkg::*;
#(
  parameter int                       KEY_BYTES = 3,
  parameter int                       MSG_LEN   = 32,
  parameter logic [8*KEY_BYTES-1:0]   KEY_START = '0,
  parameter logic [8*KEY_BYTES-1:0]   KEY_END   = 'h3FFFFF,
  parameter logic [8*KEY_BYTES-1:0]   KEY_STEP  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [7:0]               s_addr,
  output logic [7:0]               s_data,
  output logic                     s_wren,
  input  logic [7:0]               s_q,
  output logic [7:0]               rom_addr,
  input  logic [7:0]               rom_q,
  output logic [7:0]               res_addr,
  output logic [7:0]               res_data,
  output logic                     res_wren,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [8*KEY_BYTES-1:0]   key_out
);

  localparam int KEY_W = 8 * KEY_BYTES;
  localparam logic [7:0] I_LAST = 8'(S_SIZE - 1);
  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  rc4_state_t       state_q, state_d;
  rc4_phase_t       phase_q, phase_d;
  logic [7:0]       i_q, i_d, j_q, j_d, k_q, k_d, t_q, t_d;
  logic [KEY_W-1:0] key_q, key_d, kshift_q, kshift_d, key_out_q, key_out_d;
  logic             all_ok_q, all_ok_d, busy_q, busy_d, done_q, done_d, found_q, found_d;

  logic [7:0]       ext_addr, ext_data, sw_b, sw_va, sw_vb, res_byte;
  logic             ext_wren, sw_start, sw_done, byte_ok;
  logic [KEY_W:0]   key_sum;

  assign res_byte = s_q ^ rom_q;
  assign byte_ok  = is_valid_char(res_byte);
  assign key_sum  = {1'b0, key_q} + {1'b0, KEY_STEP};

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    t_d       = t_q;
    key_d     = key_q;
    kshift_d  = kshift_q;
    key_out_d = key_out_q;
    all_ok_d  = all_ok_q;
    busy_d    = busy_q;
    done_d    = done_q;
    found_d   = found_q;
    ext_addr  = '0;
    ext_data  = '0;
    ext_wren  = 1'b0;
    sw_start  = 1'b0;
    sw_b      = '0;
    rom_addr  = '0;
    res_addr  = '0;
    res_data  = '0;
    res_wren  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_INIT;
          i_d       = '0;
          key_d     = KEY_START;
          key_out_d = KEY_START;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          found_d   = 1'b0;
        end
      end
      ST_INIT: begin
        ext_addr = i_q;
        ext_data = i_q;
        ext_wren = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == I_LAST) begin
          state_d  = ST_SHUF;
          phase_d  = PH_RD;
          j_d      = '0;
          kshift_d = key_q;
        end
      end
      ST_SHUF: begin
        unique case (phase_q)
          PH_RD: begin
            ext_addr = i_q;
            phase_d  = PH_J;
          end
          PH_J: begin
            sw_b     = j_q + s_q + kshift_q[KEY_W-1 -: 8];
            j_d      = sw_b;
            sw_start = 1'b1;
            phase_d  = PH_WAIT;
          end
          PH_WAIT: begin
            if (sw_done) begin
              // rotating the key left puts key[(i+1) mod KEY_BYTES] in the top byte
              kshift_d = (kshift_q << 8) | (kshift_q >> (KEY_W - 8));
              i_d      = i_q + 8'd1;
              phase_d  = PH_RD;
              if (i_q == I_LAST) begin
                state_d  = ST_DEC;
                i_d      = 8'd1;
                j_d      = '0;
                k_d      = '0;
                all_ok_d = 1'b1;
              end
            end
          end
          default: phase_d = PH_RD;
        endcase
      end
      ST_DEC: begin
        rom_addr = k_q;
        unique case (phase_q)
          PH_RD: begin
            ext_addr = i_q;
            phase_d  = PH_J;
          end
          PH_J: begin
            sw_b     = j_q + s_q;
            j_d      = sw_b;
            sw_start = 1'b1;
            phase_d  = PH_WAIT;
          end
          PH_WAIT: begin
            if (sw_done) begin
              t_d     = sw_va + sw_vb;
              phase_d = PH_F;
            end
          end
          PH_F: begin
            ext_addr = t_q;
            phase_d  = PH_WR;
          end
          PH_WR: begin
            res_addr = k_q;
            res_data = res_byte;
            res_wren = 1'b1;
            all_ok_d = all_ok_q & byte_ok;
            k_d      = k_q + 8'd1;
            i_d      = i_q + 8'd1;
            phase_d  = PH_RD;
            if (k_q == K_LAST) state_d = ST_CHECK;
`ifdef RC4_EARLY_REJECT_EN
            if (!byte_ok) state_d = ST_NEXT_KEY;
`endif
          end
          default: phase_d = PH_RD;
        endcase
      end
      ST_CHECK: begin
        if (all_ok_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b1;
        end else begin
          state_d = ST_NEXT_KEY;
        end
      end
      ST_NEXT_KEY: begin
        if (key_sum[KEY_W] || (key_sum[KEY_W-1:0] > KEY_END)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b0;
        end else begin
          key_d     = key_sum[KEY_W-1:0];
          key_out_d = key_sum[KEY_W-1:0];
          i_d       = '0;
          state_d   = ST_INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_RD;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      t_q       <= '0;
      key_q     <= KEY_START;
      kshift_q  <= '0;
      key_out_q <= '0;
      all_ok_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      t_q       <= t_d;
      key_q     <= key_d;
      kshift_q  <= kshift_d;
      key_out_q <= key_out_d;
      all_ok_q  <= all_ok_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
    end
  end

  rc4_swap_seq u_swap (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sw_start),
    .a        (i_q),
    .b        (sw_b),
    .ext_addr (ext_addr),
    .ext_data (ext_data),
    .ext_wren (ext_wren),
    .s_q      (s_q),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .s_wren   (s_wren),
    .done     (sw_done),
    .va       (sw_va),
    .vb       (sw_vb)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign key_out = key_out_q;

endmodule

// File: tb/tb_rc4_key_search.sv
// Bench for rc4_key_search: five instances with different key ranges run against a
// ciphertext produced by a behavioural RC4 model for key 24'h000249.
module tb_rc4_key_search;

  localparam int MSG_LEN    = 32;
  localparam int N_INST     = 5;
  localparam int KEY_BUDGET = 256 + 6*256 + 8*MSG_LEN + 4;

  localparam logic [23:0] P_START [N_INST] = '{24'h249, 24'h240, 24'h250, 24'h248, 24'h249};
  localparam logic [23:0] P_END   [N_INST] = '{24'h249, 24'h24F, 24'h25F, 24'h24B, 24'h24B};
  localparam logic [23:0] P_STEP  [N_INST] = '{24'd1,   24'd1,   24'd1,   24'd2,   24'd2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N_INST-1:0] rst_v, start_v, busy_v, done_v, found_v;
  logic [23:0]       key_out_v [N_INST];
  logic [7:0]        rom   [256];
  logic [7:0]        plain [MSG_LEN];
  int                n_checks = 0;
  int                n_err    = 0;

  typedef struct {
    string       name;
    int          inst;
    logic        found;
    logic [23:0] key;
  } vec_t;
  vec_t vecs [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    logic [7:0]  s_addr, s_data, s_q, rom_addr, rom_q, res_addr, res_data;
    logic        s_wren, res_wren, busy, done, found;
    logic [23:0] key_out;
    logic [7:0]  s_mem   [256];
    logic [7:0]  res_mem [256];

    rc4_key_search #(
      .KEY_BYTES (3),
      .MSG_LEN   (MSG_LEN),
      .KEY_START (P_START[g]),
      .KEY_END   (P_END[g]),
      .KEY_STEP  (P_STEP[g])
    ) dut (
      .clk      (clk),
      .reset_n  (rst_v[g]),
      .start    (start_v[g]),
      .s_addr   (s_addr),
      .s_data   (s_data),
      .s_wren   (s_wren),
      .s_q      (s_q),
      .rom_addr (rom_addr),
      .rom_q    (rom_q),
      .res_addr (res_addr),
      .res_data (res_data),
      .res_wren (res_wren),
      .busy     (busy),
      .done     (done),
      .found    (found),
      .key_out  (key_out)
    );

    always_ff @(posedge clk) begin
      if (s_wren) s_mem[s_addr] <= s_data;
      s_q <= s_mem[s_addr];
    end
    always_ff @(posedge clk) rom_q <= rom[rom_addr];
    always_ff @(posedge clk) if (res_wren) res_mem[res_addr] <= res_data;

    assign busy_v[g]    = busy;
    assign done_v[g]    = done;
    assign found_v[g]   = found;
    assign key_out_v[g] = key_out;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference RC4: keystream for key, XORed onto the plaintext to form the ROM image
  task automatic build_rom(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j, ii, tmp, kb;
    for (int n = 0; n < 256; n++) begin
      s[n]   = 8'(n);
      rom[n] = 8'h00;
    end
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb   = key[23 - 8*(n % 3) -: 8];
      j    = j + s[n] + kb;
      tmp  = s[n];
      s[n] = s[j];
      s[j] = tmp;
    end
    ii = 8'd0;
    j  = 8'd0;
    for (int n = 0; n < MSG_LEN; n++) begin
      ii     = ii + 8'd1;
      j      = j + s[ii];
      tmp    = s[ii];
      s[ii]  = s[j];
      s[j]   = tmp;
      tmp    = s[ii] + s[j];
      rom[n] = plain[n] ^ s[tmp];
    end
  endtask

  // Instance 1 monitor: keys visited while busy, and any busy drop before done
  logic        mon_on = 1'b0;
  logic [23:0] last_key = '1;
  logic [23:0] seen_q [$];
  int          busy_gaps = 0;
  int          cyc1 = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      if (busy_v[1]) begin
        cyc1++;
        if (key_out_v[1] != last_key) begin
          seen_q.push_back(key_out_v[1]);
          last_key = key_out_v[1];
        end
      end else if (!done_v[1]) begin
        busy_gaps++;
      end
    end
  end

  initial begin
    logic [8*MSG_LEN-1:0] pt_str;
    int cyc;
    pt_str = "the quick brown fox jumps over a";
    for (int n = 0; n < MSG_LEN; n++) plain[n] = pt_str[8*(MSG_LEN-1-n) +: 8];
    build_rom(24'h000249);

    vecs[0] = '{"exact_key",   0, 1'b1, 24'h249};
    vecs[1] = '{"range_hit",   1, 1'b1, 24'h249};
    vecs[2] = '{"range_miss",  2, 1'b0, 24'h25F};
    vecs[3] = '{"stride_even", 3, 1'b0, 24'h24A};
    vecs[4] = '{"stride_odd",  4, 1'b1, 24'h249};

    rst_v   = '0;
    start_v = '0;
    repeat (3) @(negedge clk);
    check("reset_ports", {g_inst[0].s_addr, g_inst[0].s_data, g_inst[0].s_wren, g_inst[0].rom_addr,
                          g_inst[0].res_addr, g_inst[0].res_data, g_inst[0].res_wren}, 64'd0);
    check("reset_status", {busy_v, done_v, found_v, key_out_v[0]}, 64'd0);
    rst_v = '1;
    repeat (2) @(negedge clk);
    check("idle_status", {busy_v, done_v, found_v}, 64'd0);

    // all instances in parallel; instance 1 gets extra start pulses while busy
    start_v = '1;
    @(negedge clk);
    start_v = '0;
    mon_on  = 1'b1;
    check("busy_after_start", busy_v, {N_INST{1'b1}});
    cyc = 0;
    while (done_v != {N_INST{1'b1}} && cyc < 16*KEY_BUDGET + 1000) begin
      start_v[1] = (cyc == 3000 || cyc == 9001 || cyc == 15002);
      @(negedge clk);
      cyc++;
    end
    start_v = '0;
    mon_on  = 1'b0;
    check("all_done_in_time", done_v, {N_INST{1'b1}});

    for (int v = 0; v < N_INST; v++) begin
      check($sformatf("%s_status", vecs[v].name),
            {busy_v[vecs[v].inst], done_v[vecs[v].inst], found_v[vecs[v].inst]},
            {1'b0, 1'b1, vecs[v].found});
      check($sformatf("%s_key", vecs[v].name), key_out_v[vecs[v].inst], vecs[v].key);
    end

    for (int n = 0; n < MSG_LEN; n++)
      check($sformatf("plaintext[%0d]", n), g_inst[0].res_mem[n], plain[n]);

    check("key_seq_len", seen_q.size(), 64'd10);
    for (int n = 0; n < seen_q.size() && n < 10; n++)
      check($sformatf("key_seq[%0d]", n), seen_q[n], 24'h240 + 24'(n));
    check("busy_continuous", busy_gaps, 64'd0);
    check("cycles_within_budget", (cyc1 <= 10*KEY_BUDGET), 64'd1);
`ifdef RC4_EARLY_REJECT_EN
    check("early_reject_faster", (cyc1 < 10*(256 + 6*256 + 8*MSG_LEN)), 64'd1);
`endif

    // restart from DONE, then reset in the middle of the shuffle
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("restart_clears", {busy_v[0], done_v[0], found_v[0]}, 64'b100);
    repeat (400) @(negedge clk);
    check("busy_mid_shuf", busy_v[0], 64'd1);
    rst_v[0] = 1'b0;
    @(negedge clk);
    check("midreset_ports", {g_inst[0].s_addr, g_inst[0].s_data, g_inst[0].s_wren, g_inst[0].rom_addr,
                             g_inst[0].res_addr, g_inst[0].res_data, g_inst[0].res_wren}, 64'd0);
    check("midreset_status", {busy_v[0], done_v[0], found_v[0], key_out_v[0]}, 64'd0);
    rst_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 0;
    while (!done_v[0] && cyc < 2*KEY_BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("rerun_status", {busy_v[0], done_v[0], found_v[0]}, 64'b011);
    check("rerun_key", key_out_v[0], 24'h249);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
